layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_seq_pkg.sv | 16 +
 rtl/seq_step_counter.sv | 35 +++
 rtl/layer_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - shared state encoding and drain latency for layer_sequencer
package layer_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CLEAR    = 3'd1;
  localparam state_t ST_ISSUE    = 3'd2;
  localparam state_t ST_DRAIN    = 3'd3;
  localparam state_t ST_HOLD_OUT = 3'd4;

  // Cycles between the final mac_en cycle and the cycle that captures mac_out.
  localparam int unsigned DRAIN_LAT   = 2;
  localparam int unsigned DRAIN_CNT_W = 2;

endpackage

// File: rtl/seq_step_counter.sv
// rtl/seq_step_counter.sv - step counter k and read address generator for layer_sequencer
module seq_step_counter #(
  parameter int ACCUMULATIONS = 3,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int KW = $clog2(ACCUMULATIONS + 1);

  logic [KW-1:0] k;

  // Load the job base on accept, then advance k and the address together on each issued step.
  always_ff @(posedge clk) begin
    if (reset) begin
      k    <= '0;
      addr <= '0;
    end else if (load) begin
      k    <= '0;
      addr <= base_addr;
    end else if (step) begin
      k    <= k + KW'(1);
      addr <= addr + ADDR_WIDTH'(1);
    end
  end

  assign last = (k == KW'(ACCUMULATIONS - 1));

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - drives an external vsmac through one N-step job; optional LAYER_SEQ_PERF_EN adds perf_cycles
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int SIZE          = 6,
  parameter int WIDTH         = 8,
  parameter int ACCUMULATIONS = 3,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0]             perf_cycles,
`endif
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    hold,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   x_addr,
  input  logic [WIDTH-1:0]        x_rdata,
  output logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [WIDTH*SIZE-1:0]   w_rdata,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic [WIDTH*SIZE-1:0]   mac_a,
  output logic [WIDTH-1:0]        mac_b,
  input  logic [WIDTH*SIZE-1:0]   mac_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH*SIZE-1:0]   res_data
);

  state_t                 state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   accept;
  logic                   issue_fire;
  logic                   last_step;

  assign accept     = (state == ST_IDLE) && start;
  assign issue_fire = (state == ST_ISSUE) && !hold;
  assign busy       = (state != ST_IDLE);
  assign mac_clr    = reset || (state == ST_CLEAR);
  assign mac_a      = w_rdata;
  assign mac_b      = x_rdata;
  assign w_addr     = x_addr;

  seq_step_counter #(
    .ACCUMULATIONS (ACCUMULATIONS),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_step (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .base_addr (base_addr),
    .step      (issue_fire),
    .addr      (x_addr),
    .last      (last_step)
  );

  // Job FSM plus the enable pipeline: data for an issued address arrives one cycle later, so mac_en follows issue_fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      mac_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      mac_en <= issue_fire;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (issue_fire && last_step) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_CNT_W'(DRAIN_LAT)) begin
            res_data  <= mac_out;
            res_valid <= 1'b1;
            state     <= ST_HOLD_OUT;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
          end
        end
        ST_HOLD_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  // Busy-cycle counter: cleared on accept, saturating, frozen while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
